mac_pipe_ctrl: RTL

Sequencer for the neuron MAC pipeline built from the team's `Register` pipeline stages. On a start request it walks an operand address counter across N input/weight pairs, and injects a `pipe_enable` token each cycle plus a `pipe_restart` token on the first term to clear the accumulator. It then waits for the fixed-depth pipeline to drain and flags the result. It sits between the layer-level scheduler (start/done) and the operand memories plus the first pipeline register (enable_in/restart_in).

---
 rtl/mac_pipe_ctrl.sv | 105 ++++++++++
 1 files changed

// File: rtl/mac_pipe_ctrl.sv
// Issue sequencer for the neuron MAC pipeline. It walks the operand addresses, injects
// enable/restart tokens into stage 1, waits for the pipeline to drain, then pulses done.
module mac_pipe_ctrl #(
  parameter int ADDR_W     = 8,
  parameter int PIPE_DEPTH = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] num_terms,
  input  logic              stall,
  input  logic              abort,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              pipe_enable,
  output logic              pipe_restart,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  // The drain count starts one below the depth because the cycle that counts down to 0 is
  // itself a drain cycle.
  localparam logic [3:0] DRAIN_INIT = 4'(PIPE_DEPTH - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [ADDR_W-1:0] n_lat_q, n_lat_d;
  logic [3:0]        drain_cnt_q, drain_cnt_d;
  logic              err_q, err_d;
  logic              last_term;

  assign last_term = (idx_q == n_lat_q - ADDR_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      n_lat_q     <= '0;
      drain_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      n_lat_q     <= n_lat_d;
      drain_cnt_q <= drain_cnt_d;
      err_q       <= err_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    n_lat_d      = n_lat_q;
    drain_cnt_d  = drain_cnt_q;
    err_d        = 1'b0;
    pipe_enable  = 1'b0;
    pipe_restart = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (num_terms != '0) begin
            n_lat_d = num_terms;
            idx_d   = '0;
            state_d = ISSUE;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ISSUE: begin
        pipe_enable  = ~stall;
        pipe_restart = ~stall & (idx_q == '0);
        if (abort) begin
          state_d = IDLE;
        end else if (!stall) begin
          if (last_term) begin
            state_d     = DRAIN;
            drain_cnt_d = DRAIN_INIT;
          end else begin
            idx_d = idx_q + ADDR_W'(1);
          end
        end
      end
      DRAIN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (drain_cnt_q == 4'd0) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q - 4'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;
  assign mem_addr = idx_q;

endmodule
